// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the 32 x 32-bit register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 32;
    localparam int IDX_W      = 5;
    localparam int ZERO_REG   = 0;

    typedef logic [DATA_WIDTH-1:0] reg_word_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_wdec.sv
// ============================================================================
//  Module      : regfile_wdec
//  Description : One-hot write-enable decoder; slot 0 (x0) never enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wdec #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             we_i,
    output logic [DEPTH-1:0] wr_en_o
);

    // x0 is hardwired to zero, so its enable is tied off rather than decoded.
    assign wr_en_o[0] = 1'b0;

    for (genvar g = 1; g < DEPTH; g++) begin : g_dec
        assign wr_en_o[g] = we_i && (idx_i == IDX_W'(g));
    end

endmodule : regfile_wdec

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
//  Module      : regfile
//  Description : Single-port register file, combinational read, sync write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int DEPTH      = regfile_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           register,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] readData
);

    import regfile_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0]      w_idx;
    logic                  w_unused_upper;
    logic [DEPTH-1:0]      w_wr_en;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Upper index bits alias away: index 44 addresses register 12.
    assign w_idx          = register[IDX_W-1:0];
    assign w_unused_upper = ^register[31:IDX_W];

    regfile_wdec #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_wdec (
        .idx_i   (w_idx),
        .we_i    (writeEnable),
        .wr_en_o (w_wr_en)
    );

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_en[i]) begin
                regs_d[i] = writeData;
            end
        end
    end

    // Reset wins over a coincident write; the write is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign readData = (w_idx == IDX_W'(ZERO_REG)) ? '0 : regs_q[w_idx];

endmodule : regfile

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
//  Module      : tb_regfile
//  Description : Self-checking bench: directed vector table, corner sequences,
//                and random traffic against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        writeEnable;
    logic [31:0] register;
    logic [31:0] writeData;
    logic [31:0] readData;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile #(
        .DATA_WIDTH (32),
        .DEPTH      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .register    (register),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .readData    (readData)
    );

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] idx;
        logic [31:0] d;
        logic [31:0] rd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the given controls; the model follows the register-file rules.
    task automatic step(input bit r, input bit w, input logic [31:0] idx, input logic [31:0] d);
        rst         = r;
        writeEnable = w;
        register    = idx;
        writeData   = d;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (w && (idx % 32) != 0) begin
            model[idx % 32] = d;
        end
        rst         = 1'b0;
        writeEnable = 1'b0;
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] idx);
        return ((idx % 32) == 0) ? 32'd0 : model[idx % 32];
    endfunction

    task automatic rd_check(input string name, input logic [31:0] idx);
        register = idx;
        #1;
        check(name, readData, ref_read(idx));
    endtask

    initial begin
        rst         = 1'b1;
        writeEnable = 1'b0;
        register    = 32'd0;
        writeData   = 32'd0;

        tbl[0]  = '{1'b1, 1'b0, 32'd0,  32'd0,          32'd0,  32'd0,  "rst_x0"};
        tbl[1]  = '{1'b1, 1'b0, 32'd0,  32'd0,          32'd31, 32'd0,  "rst_x31"};
        tbl[2]  = '{1'b0, 1'b0, 32'd0,  32'd0,          32'd10, 32'd0,  "rst_x10"};
        tbl[3]  = '{1'b0, 1'b1, 32'd12, 32'd6,          32'd12, 32'd6,  "wr12"};
        tbl[4]  = '{1'b0, 1'b1, 32'd10, 32'd5,          32'd10, 32'd5,  "wr10"};
        tbl[5]  = '{1'b0, 1'b1, 32'd0,  32'hDEADBEEF,   32'd0,  32'd0,  "x0_prot"};
        tbl[6]  = '{1'b0, 1'b0, 32'd12, 32'd99,         32'd12, 32'd6,  "we0_hold"};
        tbl[7]  = '{1'b0, 1'b0, 32'd12, 32'd99,         32'd44, 32'd6,  "alias44_rd"};
        tbl[8]  = '{1'b1, 1'b1, 32'd7,  32'd3,          32'd7,  32'd0,  "rst_prio"};
        tbl[9]  = '{1'b0, 1'b0, 32'd0,  32'd0,          32'd10, 32'd0,  "rst_clr10"};
        tbl[10] = '{1'b0, 1'b0, 32'd0,  32'd0,          32'd12, 32'd0,  "rst_clr12"};
        tbl[11] = '{1'b0, 1'b1, 32'h2C, 32'd77,         32'd12, 32'd77, "alias44_wr"};

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].w, tbl[i].idx, tbl[i].d);
            register = tbl[i].rd;
            #1;
            check(tbl[i].name, readData, tbl[i].exp);
        end

        // Combinational read: index changes between edges, no clock involved.
        step(1'b0, 1'b1, 32'd20, 32'h0000A5A5);
        step(1'b0, 1'b1, 32'd21, 32'h00005A5A);
        register = 32'd20; #1; check("comb_rd20", readData, 32'h0000A5A5);
        register = 32'd21; #1; check("comb_rd21", readData, 32'h00005A5A);
        register = 32'd52; #1; check("comb_rd52", readData, 32'h0000A5A5);

        // Read-during-write: old value before the edge, new value after it.
        step(1'b0, 1'b1, 32'd5, 32'd1);
        writeEnable = 1'b1;
        register    = 32'd5;
        writeData   = 32'd2;
        #1;
        check("rdw_before", readData, 32'd1);
        @(posedge clk);
        #1;
        check("rdw_after", readData, 32'd2);
        writeEnable = 1'b0;
        model[5]    = 32'd2;

        // Reset right after a write clears the freshly written register.
        step(1'b0, 1'b1, 32'd9, 32'h00001234);
        step(1'b1, 1'b0, 32'd0, 32'd0);
        register = 32'd9; #1; check("rst_after_wr", readData, 32'd0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), $urandom, $urandom);
            rd_check("rand_rd", $urandom);
        end
        for (int i = 0; i < 32; i++) begin
            rd_check("sweep_rd", i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile

`default_nettype wire
